// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter and other shared-resource controllers.
package mult_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NREQ_MAX        = 8;
  localparam int TIMEOUT_DEFAULT = 63;

endpackage

// File: rtl/mult_share_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_priority_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic          found;
  int            pos;
  logic [IW-1:0] pos_i;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    pos_i  = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N) pos = pos - N;
      pos_i = IW'(pos);
      if (!found && req[pos_i]) begin
        found = 1'b1;
        idx   = pos_i;
      end
    end
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin owner of a shared sequential signed multiplier: grant, launch, wait for a
// fresh ready (or time out), return the product with a one-cycle done to the owner.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NBits   = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBits-1:0] op_a,
  input  logic [NREQ*NBits-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [2*NBits-1:0]    result,
  output logic                  timeout_err,
  output logic                  busy,
  output logic                  mul_start,
  output logic [NBits-1:0]      mul_multiplier,
  output logic [NBits-1:0]      mul_multiplicand,
  input  logic                  mul_ready,
  input  logic [2*NBits-1:0]    mul_product,
  output state_t                state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  // Handshake: a requester raises req with its operands and holds them until it sees its
  // done bit; done is a single-cycle pulse and result is valid in that cycle.
  state_t            state, state_d;
  logic [NREQ-1:0]   gnt_d, done_d, pick_onehot;
  logic [IW-1:0]     ptr, ptr_d, owner, owner_d, pick_idx;
  logic              pick_any;
  logic [2*NBits-1:0] result_d;
  logic              timeout_err_d, busy_d, mul_start_d, armed, armed_d;
  logic [NBits-1:0]  mul_multiplier_d, mul_multiplicand_d;
  logic [CW-1:0]     cnt, cnt_d;

  rr_priority_pick #(.N(NREQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign pick_any  = |req;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d            = state;
    gnt_d              = gnt;
    done_d             = '0;
    result_d           = result;
    timeout_err_d      = timeout_err;
    busy_d             = busy;
    mul_start_d        = 1'b0;
    mul_multiplier_d   = mul_multiplier;
    mul_multiplicand_d = mul_multiplicand;
    cnt_d              = cnt;
    armed_d            = armed;
    ptr_d              = ptr;
    owner_d            = owner;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_d            = LAUNCH;
          gnt_d              = pick_onehot;
          owner_d            = pick_idx;
          busy_d             = 1'b1;
          mul_start_d        = 1'b1;
          mul_multiplier_d   = op_a[int'(pick_idx)*NBits +: NBits];
          mul_multiplicand_d = op_b[int'(pick_idx)*NBits +: NBits];
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
        armed_d = 1'b0;
      end
      WAIT: begin
        cnt_d = cnt + 1'b1;
        // A ready seen before any low level is left over from the previous operation.
        if (!mul_ready) armed_d = 1'b1;
        if (armed && mul_ready) begin
          state_d       = DONE;
          result_d      = mul_product;
          timeout_err_d = 1'b0;
          done_d        = gnt;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          state_d       = DONE;
          result_d      = '0;
          timeout_err_d = 1'b1;
          done_d        = gnt;
        end
      end
      DONE: begin
        state_d       = IDLE;
        gnt_d         = '0;
        busy_d        = 1'b0;
        timeout_err_d = 1'b0;
        ptr_d         = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt              <= '0;
      done             <= '0;
      result           <= '0;
      timeout_err      <= 1'b0;
      busy             <= 1'b0;
      mul_start        <= 1'b0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      cnt              <= '0;
      armed            <= 1'b0;
      ptr              <= '0;
      owner            <= '0;
    end else begin
      gnt              <= gnt_d;
      done             <= done_d;
      result           <= result_d;
      timeout_err      <= timeout_err_d;
      busy             <= busy_d;
      mul_start        <= mul_start_d;
      mul_multiplier   <= mul_multiplier_d;
      mul_multiplicand <= mul_multiplicand_d;
      cnt              <= cnt_d;
      armed            <= armed_d;
      ptr              <= ptr_d;
      owner            <= owner_d;
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier with scripted ready timing and a
// round-robin/latency reference model derived from the arbitration rules.
`timescale 1ns/1ps
module tb_mult_share_arbiter;
  import mult_share_arbiter_pkg::*;

  localparam int NBITS   = 8;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 63;
  localparam int PW      = 2 * NBITS;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*NBITS-1:0] op_a = '0, op_b = '0;
  logic [NREQ-1:0]       gnt, done;
  logic [PW-1:0]         result;
  logic                  timeout_err, busy, mul_start;
  logic [NBITS-1:0]      mul_multiplier, mul_multiplicand;
  logic                  mul_ready = 1'b1;
  logic [PW-1:0]         mul_product = '0;
  state_t                state_dbg;

  int n_vec = 0, n_err = 0;
  int ref_ptr = 0;
  int cfg_stale = 0, cfg_low = 4;
  int m_stale = 0, m_low = 0;
  bit m_active = 0;
  logic [PW-1:0] m_prod = '0;

  mult_share_arbiter #(.NBits(NBITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .done(done), .result(result), .timeout_err(timeout_err), .busy(busy),
    .mul_start(mul_start), .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
    .mul_ready(mul_ready), .mul_product(mul_product), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: after start, ready stays high cfg_stale cycles, low cfg_low cycles,
  // then rises with the product. Product reads as junk until the real ready.
  always @(negedge clk) begin
    if (rst) begin
      mul_ready = 1'b1;
      m_active  = 0;
    end else if (mul_start) begin
      m_stale     = cfg_stale;
      m_low       = cfg_low;
      m_active    = 1;
      m_prod      = $signed(mul_multiplier) * $signed(mul_multiplicand);
      mul_product = 16'hA5A5;
    end else if (m_active) begin
      if (m_stale > 0) begin
        mul_ready = 1'b1;
        m_stale--;
      end else if (m_low > 0) begin
        mul_ready = 1'b0;
        m_low--;
      end else begin
        mul_ready   = 1'b1;
        mul_product = m_prod;
        m_active    = 0;
      end
    end
  end

  // One full operation from the IDLE cycle in which req is already driven.
  task automatic do_op(input string tag, input int stale, input int low,
                       input int drop_at, input logic [NREQ-1:0] drop_mask);
    int w, a, b, k, c;
    logic to;
    logic [PW-1:0] exp_res;
    logic [NREQ-1:0] exp_gnt;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (ref_ptr + i) % NREQ;
      if (w < 0 && req[j]) w = j;
    end
    if (w < 0) return;
    exp_gnt = '0;
    exp_gnt[w] = 1'b1;
    a = $signed(op_a[w*NBITS +: NBITS]);
    b = $signed(op_b[w*NBITS +: NBITS]);
    if (low > 0 && stale + low + 1 <= TIMEOUT) begin
      k = stale + low + 1; to = 1'b0; exp_res = PW'(a * b);
    end else begin
      k = TIMEOUT; to = 1'b1; exp_res = '0;
    end
    cfg_stale = stale;
    cfg_low   = low;
    @(posedge clk); #1;
    n_vec++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL %s_grant got %b want %b", tag, gnt, exp_gnt); end
    n_vec++; if (busy !== 1'b1 || mul_start !== 1'b1) begin n_err++; $display("FAIL %s_launch busy=%b start=%b want 1/1", tag, busy, mul_start); end
    n_vec++; if (mul_multiplier !== NBITS'(a) || mul_multiplicand !== NBITS'(b))
      begin n_err++; $display("FAIL %s_operands got %h/%h want %h/%h", tag, mul_multiplier, mul_multiplicand, NBITS'(a), NBITS'(b)); end
    op_a = (NREQ*NBITS)'($urandom);
    op_b = (NREQ*NBITS)'($urandom);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
      if (c == drop_at) req = req & ~drop_mask;
      if (done === '0) begin
        n_vec++; if (gnt !== exp_gnt || mul_start !== 1'b0)
          begin n_err++; $display("FAIL %s_hold cyc %0d gnt=%b start=%b want %b/0", tag, c, gnt, mul_start, exp_gnt); end
      end
    end while (done === '0 && c < TIMEOUT + 8);
    n_vec++; if (c != k + 1) begin n_err++; $display("FAIL %s_latency got %0d want %0d", tag, c, k + 1); end
    n_vec++; if (done !== exp_gnt) begin n_err++; $display("FAIL %s_done got %b want %b", tag, done, exp_gnt); end
    n_vec++; if (result !== exp_res) begin n_err++; $display("FAIL %s_result got %h want %h", tag, result, exp_res); end
    n_vec++; if (timeout_err !== to) begin n_err++; $display("FAIL %s_timeout_err got %b want %b", tag, timeout_err, to); end
    @(posedge clk); #1;
    n_vec++; if (done !== '0 || gnt !== '0 || busy !== 1'b0 || timeout_err !== 1'b0 || state_dbg !== IDLE)
      begin n_err++; $display("FAIL %s_release done=%b gnt=%b busy=%b to=%b", tag, done, gnt, busy, timeout_err); end
    n_vec++; if (result !== exp_res) begin n_err++; $display("FAIL %s_result_hold got %h want %h", tag, result, exp_res); end
    ref_ptr = (w + 1) % NREQ;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    ref_ptr = 0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = '1;
    op_a = (NREQ*NBITS)'($urandom);
    op_b = (NREQ*NBITS)'($urandom);
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (gnt !== '0 || done !== '0) begin n_err++; $display("FAIL reset_gnt_done got %b/%b want 0/0", gnt, done); end
    n_vec++; if (result !== '0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_result got %h/%b want 0/0", result, timeout_err); end
    n_vec++; if (busy !== 1'b0 || mul_start !== 1'b0) begin n_err++; $display("FAIL reset_busy_start got %b/%b want 0/0", busy, mul_start); end
    n_vec++; if (mul_multiplier !== '0 || mul_multiplicand !== '0) begin n_err++; $display("FAIL reset_operands got %h/%h want 0/0", mul_multiplier, mul_multiplicand); end
    n_vec++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", state_dbg, IDLE); end
    rst = 1'b0;
    req = '0;
    ref_ptr = 0;
  endtask

  task automatic test_basic();
    op_a = '0; op_b = '0;
    op_a[NBITS-1:0] = 8'd5;
    op_b[NBITS-1:0] = 8'hFD;
    req = 3'b001;
    do_op("basic", 0, 10, -1, '0);
    n_vec++; if (result !== 16'hFFF1) begin n_err++; $display("FAIL basic_const got %h want fff1", result); end
    req = '0;
  endtask

  task automatic test_alternate();
    apply_reset(2);
    req = 3'b011;
    do_op("alt0", 0, 3, -1, '0);
    do_op("alt1", 0, 5, -1, '0);
    do_op("alt2", 0, 2, -1, '0);
    req = '0;
  endtask

  task automatic test_stale_ready();
    req = 3'b001;
    do_op("stale", 1, 2, -1, '0);
    req = '0;
  endtask

  task automatic test_timeout();
    req = 3'b010;
    do_op("timeout", 0, 1000, -1, '0);
    req = 3'b100;
    do_op("after_to", 0, 5, -1, '0);
    req = 3'b001;
    do_op("edge_ok", 0, TIMEOUT - 1, -1, '0);
    req = 3'b010;
    do_op("edge_to", 0, TIMEOUT, -1, '0);
    req = '0;
  endtask

  task automatic test_drop();
    apply_reset(1);
    req = 3'b001;
    do_op("drop_pre", 0, 2, -1, '0);
    req = 3'b011;
    do_op("drop", 0, 8, 3, 3'b010);
    do_op("drop_next", 0, 3, -1, '0);
    req = '0;
  endtask

  task automatic test_reset_mid();
    req = 3'b001;
    do_op("rm_pre", 0, 4, -1, '0);
    req = 3'b010;
    cfg_stale = 0;
    cfg_low   = 20;
    @(posedge clk); #1;
    n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rm_grant got %b want 010", gnt); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_ptr = 0;
    n_vec++; if (gnt !== '0 || busy !== 1'b0 || mul_start !== 1'b0)
      begin n_err++; $display("FAIL rm_ctrl gnt=%b busy=%b start=%b want 0", gnt, busy, mul_start); end
    n_vec++; if (result !== '0 || done !== '0 || timeout_err !== 1'b0)
      begin n_err++; $display("FAIL rm_result got %h done=%b to=%b want 0", result, done, timeout_err); end
    n_vec++; if (mul_multiplier !== '0 || state_dbg !== IDLE)
      begin n_err++; $display("FAIL rm_state got %h/%0d want 0/%0d", mul_multiplier, state_dbg, IDLE); end
    req = 3'b011;
    do_op("rm_ptr", 0, 3, -1, '0);
    req = 3'b010;
    do_op("rm_r1", 0, 3, -1, '0);
    req = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int st, lo;
      if (n == 0 || $urandom_range(0, 1) == 1) req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      op_a = (NREQ*NBITS)'($urandom);
      op_b = (NREQ*NBITS)'($urandom);
      st = $urandom_range(0, 2);
      lo = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 14);
      do_op("rand", st, lo, -1, '0);
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_stale_ready();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
